// File: rtl/rpmul_pipe.sv
// rtl/rpmul_pipe.sv - pipelined reduced-precision FP32 multiplier with tag, DAZ and sticky flags
module rpmul_pipe #(
    parameter int MANT_W = 10,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_exc,
    output logic [3:0]       sticky_exc,
    input  logic             exc_clr
);
    localparam int PW = 2 * MANT_W + 2;

    logic v1, v2, v3;
    logic load1, load2, load3;

    // Ready chain: a stage loads when empty or when the stage after it moves.
    assign load3     = ~v3 | out_ready;
    assign load2     = ~v2 | load3;
    assign load1     = ~v1 | load2;
    assign in_ready  = load1;
    assign out_valid = v3;

    // Operand classification on the retained fraction bits only.
    logic [MANT_W-1:0] fa, fb;
    logic              a_ones, a_zexp, b_ones, b_zexp, a_fnz, b_fnz;
    logic              unused_low_bits;

    assign fa     = in_a[22 -: MANT_W];
    assign fb     = in_b[22 -: MANT_W];
    assign a_ones = &in_a[30:23];
    assign b_ones = &in_b[30:23];
    assign a_zexp = ~|in_a[30:23];
    assign b_zexp = ~|in_b[30:23];
    assign a_fnz  = |fa;
    assign b_fnz  = |fb;
    assign unused_low_bits = ^{in_a[22-MANT_W:0], in_b[22-MANT_W:0]};

    // Stage 1 state
    logic              s1_sign, s1_daz;
    logic [7:0]        s1_ea, s1_eb;
    logic [MANT_W-1:0] s1_ma, s1_mb;
    logic              s1_a_nan, s1_a_inf, s1_a_zero;
    logic              s1_b_nan, s1_b_inf, s1_b_zero;
    logic [TAG_W-1:0]  s1_tag;

    // Stage 2 datapath
    logic [PW-1:0] prod_c;
    logic [9:0]    esum_c;

    assign prod_c = PW'({1'b1, s1_ma}) * PW'({1'b1, s1_mb});
    assign esum_c = 10'(s1_ea) + 10'(s1_eb) - 10'd127;

    logic             s2_sign, s2_daz, s2_nan, s2_inf, s2_zero;
    logic [PW-1:0]    s2_prod;
    logic [9:0]       s2_esum;
    logic [TAG_W-1:0] s2_tag;

    // Stage 3 datapath: normalise, range check and pack by result priority.
    logic              norm;
    logic signed [9:0] e_c;
    logic [22:0]       frac_c;
    logic [31:0]       p_c;
    logic [3:0]        exc_c;

    assign norm   = s2_prod[PW-1];
    assign e_c    = $signed(s2_esum) + $signed({9'd0, norm});
    assign frac_c = norm ? (23'(s2_prod[2*MANT_W:0])   << (22 - 2*MANT_W))
                         : (23'(s2_prod[2*MANT_W-1:0]) << (23 - 2*MANT_W));

    always_comb begin
        p_c   = {s2_sign, e_c[7:0], frac_c};
        exc_c = {3'b000, s2_daz};
        if (s2_nan) begin
            p_c      = {s2_sign, 8'hFF, 23'h400000};
            exc_c[3] = 1'b1;
        end else if (s2_inf) begin
            p_c = {s2_sign, 8'hFF, 23'h0};
        end else if (s2_zero) begin
            p_c = {s2_sign, 31'h0};
        end else if (e_c >= 10'sd255) begin
            p_c      = {s2_sign, 8'hFF, 23'h0};
            exc_c[2] = 1'b1;
        end else if (e_c <= 10'sd0) begin
            p_c      = {s2_sign, 31'h0};
            exc_c[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            s1_sign <= 1'b0; s1_daz <= 1'b0; s1_ea <= '0; s1_eb <= '0;
            s1_ma <= '0; s1_mb <= '0; s1_tag <= '0;
            s1_a_nan <= 1'b0; s1_a_inf <= 1'b0; s1_a_zero <= 1'b0;
            s1_b_nan <= 1'b0; s1_b_inf <= 1'b0; s1_b_zero <= 1'b0;
            s2_sign <= 1'b0; s2_daz <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0;
            s2_zero <= 1'b0; s2_prod <= '0; s2_esum <= '0; s2_tag <= '0;
            out_p <= '0; out_tag <= '0; out_exc <= '0; sticky_exc <= '0;
        end else begin
            if (load1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_sign   <= in_a[31] ^ in_b[31];
                    s1_ea     <= in_a[30:23];
                    s1_eb     <= in_b[30:23];
                    s1_ma     <= fa;
                    s1_mb     <= fb;
                    s1_a_nan  <= a_ones & a_fnz;
                    s1_a_inf  <= a_ones & ~a_fnz;
                    s1_a_zero <= a_zexp;
                    s1_b_nan  <= b_ones & b_fnz;
                    s1_b_inf  <= b_ones & ~b_fnz;
                    s1_b_zero <= b_zexp;
                    s1_daz    <= (a_zexp & a_fnz) | (b_zexp & b_fnz);
                    s1_tag    <= in_tag;
                end
            end
            if (load2) begin
                v2 <= v1;
                if (v1) begin
                    s2_sign <= s1_sign;
                    s2_prod <= prod_c;
                    s2_esum <= esum_c;
                    s2_nan  <= s1_a_nan | s1_b_nan | (s1_a_inf & s1_b_zero) | (s1_a_zero & s1_b_inf);
                    s2_inf  <= s1_a_inf | s1_b_inf;
                    s2_zero <= s1_a_zero | s1_b_zero;
                    s2_daz  <= s1_daz;
                    s2_tag  <= s1_tag;
                end
            end
            if (load3) begin
                v3 <= v2;
                if (v2) begin
                    out_p   <= p_c;
                    out_tag <= s2_tag;
                    out_exc <= exc_c;
                end
            end
            // Clear wins over a flag arriving in the same cycle.
            if (exc_clr)
                sticky_exc <= '0;
            else if (v3 && out_ready)
                sticky_exc <= sticky_exc | out_exc;
        end
    end
endmodule

// File: tb/tb_rpmul_pipe.sv
// tb/tb_rpmul_pipe.sv - self-checking bench for rpmul_pipe (MANT_W=10 and MANT_W=7 instances)
module tb_rpmul_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, exc_clr;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;

    logic        ir10, ov10, ir7, ov7;
    logic [31:0] p10, p7;
    logic [3:0]  tag10, tag7, exc10, exc7, sticky10, sticky7;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [35:0] r10;
        logic [35:0] r7;
    } exp_t;

    always #5 clk = ~clk;

    rpmul_pipe #(.MANT_W(10), .TAG_W(4)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir10),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov10), .out_ready(out_ready), .out_p(p10), .out_tag(tag10),
        .out_exc(exc10), .sticky_exc(sticky10), .exc_clr(exc_clr)
    );

    rpmul_pipe #(.MANT_W(7), .TAG_W(4)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir7),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov7), .out_ready(out_ready), .out_p(p7), .out_tag(tag7),
        .out_exc(exc7), .sticky_exc(sticky7), .exc_clr(exc_clr)
    );

    // Reference: classify, then multiply the truncated operands exactly in double precision.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input int m);
        logic [22:0] mask, fa, fb;
        logic [7:0]  ea, eb, e8;
        logic [10:0] da, db;
        logic        s, daz, a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
        real         ra, rb;
        logic [63:0] pb;
        int          e32;
        mask   = 23'h7FFFFF << (23 - m);
        fa     = a[22:0] & mask;
        fb     = b[22:0] & mask;
        ea     = a[30:23];
        eb     = b[30:23];
        s      = a[31] ^ b[31];
        a_nan  = (ea == 8'hFF) && (fa != 0);
        a_inf  = (ea == 8'hFF) && (fa == 0);
        a_zero = (ea == 8'h00);
        b_nan  = (eb == 8'hFF) && (fb != 0);
        b_inf  = (eb == 8'hFF) && (fb == 0);
        b_zero = (eb == 8'h00);
        daz    = (a_zero && fa != 0) || (b_zero && fb != 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            return {3'b100, daz, s, 8'hFF, 23'h400000};
        if (a_inf || b_inf)
            return {3'b000, daz, s, 8'hFF, 23'h0};
        if (a_zero || b_zero)
            return {3'b000, daz, s, 31'h0};
        da  = {3'b000, ea} + 11'd896;
        db  = {3'b000, eb} + 11'd896;
        ra  = $bitstoreal({1'b0, da, fa, 29'd0});
        rb  = $bitstoreal({1'b0, db, fb, 29'd0});
        pb  = $realtobits(ra * rb);
        e32 = int'(pb[62:52]) - 896;
        if (e32 >= 255)
            return {3'b010, daz, s, 8'hFF, 23'h0};
        if (e32 <= 0)
            return {3'b001, daz, s, 31'h0};
        e8 = 8'(e32);
        return {3'b000, daz, s, e8, pb[51:29]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else if (r < 5)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, waits for acceptance and then for out_valid; lat counts edges from acceptance.
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                                  output int lat);
        int k;
        out_ready = 1'b1;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        #1;
        k = 0;
        while (!ir10 && k < 20) begin
            tick();
            #1;
            k++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!ov10 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (ov10 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov10); end
        n_checks++; if (ir10 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir10); end
        n_checks++; if (p10 !== 32'h0) begin n_fail++; $display("FAIL reset_out_p got %h want 0", p10); end
        n_checks++; if (tag10 !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", tag10); end
        n_checks++; if (exc10 !== 4'h0) begin n_fail++; $display("FAIL reset_out_exc got %b want 0", exc10); end
        n_checks++; if (sticky10 !== 4'h0) begin n_fail++; $display("FAIL reset_sticky got %b want 0", sticky10); end
        n_checks++; if ({ov7, ir7, p7} !== {1'b0, 1'b1, 32'h0}) begin n_fail++; $display("FAIL reset_dut7 got %b%b %h", ov7, ir7, p7); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] ta [9] = '{32'h3FC00000, 32'h3FC00000, 32'h3F800001, 32'h3F808000, 32'h7F800000,
                                32'hFF800000, 32'h00400000, 32'hFFC00000, 32'hC0000000};
        logic [31:0] tb [9] = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                                32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3FC00000};
        logic [31:0] w10 [9] = '{32'h40400000, 32'h40100000, 32'h3F800000, 32'h3F808000, 32'h7FC00000,
                                 32'hFF800000, 32'h00000000, 32'hFFC00000, 32'hC0400000};
        logic [31:0] w7 [9]  = '{32'h40400000, 32'h40100000, 32'h3F800000, 32'h3F800000, 32'h7FC00000,
                                 32'hFF800000, 32'h00000000, 32'hFFC00000, 32'hC0400000};
        logic [3:0]  we [9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        logic [3:0]  tg;
        int lat;
        for (int i = 0; i < 9; i++) begin
            tg = 4'(i + 3);
            issue_and_wait(ta[i], tb[i], tg, lat);
            n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 3", i, lat); end
            n_checks++; if (p10 !== w10[i]) begin n_fail++; $display("FAIL dir%0d_p10 got %h want %h", i, p10, w10[i]); end
            n_checks++; if (exc10 !== we[i]) begin n_fail++; $display("FAIL dir%0d_exc10 got %b want %b", i, exc10, we[i]); end
            n_checks++; if (tag10 !== tg) begin n_fail++; $display("FAIL dir%0d_tag got %h want %h", i, tag10, tg); end
            n_checks++; if ({exc7, p7, tag7} !== {we[i], w7[i], tg}) begin n_fail++; $display("FAIL dir%0d_dut7 got %b %h %h want %b %h %h", i, exc7, p7, tag7, we[i], w7[i], tg); end
        end
    endtask

    task automatic test_range_sticky();
        int lat;
        exc_clr = 1'b1;
        tick();
        exc_clr = 1'b0;
        n_checks++; if (sticky10 !== 4'b0000) begin n_fail++; $display("FAIL clr_initial got %b want 0000", sticky10); end
        issue_and_wait(32'h7F000000, 32'h7F000000, 4'hA, lat);
        n_checks++; if ({exc10, p10} !== {4'b0100, 32'h7F800000}) begin n_fail++; $display("FAIL overflow got %b %h want 0100 7f800000", exc10, p10); end
        n_checks++; if ({exc7, p7} !== {4'b0100, 32'h7F800000}) begin n_fail++; $display("FAIL overflow7 got %b %h want 0100 7f800000", exc7, p7); end
        issue_and_wait(32'h00800000, 32'h00800000, 4'hB, lat);
        n_checks++; if ({exc10, p10} !== {4'b0010, 32'h0}) begin n_fail++; $display("FAIL underflow got %b %h want 0010 00000000", exc10, p10); end
        tick();
        n_checks++; if (sticky10 !== 4'b0110) begin n_fail++; $display("FAIL sticky_accum got %b want 0110", sticky10); end
        n_checks++; if (sticky7 !== 4'b0110) begin n_fail++; $display("FAIL sticky_accum7 got %b want 0110", sticky7); end
        exc_clr = 1'b1;
        tick();
        exc_clr = 1'b0;
        n_checks++; if (sticky10 !== 4'b0000) begin n_fail++; $display("FAIL sticky_clear got %b want 0000", sticky10); end
        issue_and_wait(32'h7F000000, 32'h7F000000, 4'hC, lat);
        exc_clr = 1'b1;
        tick();
        exc_clr = 1'b0;
        n_checks++; if (sticky10 !== 4'b0000) begin n_fail++; $display("FAIL clr_priority got %b want 0000", sticky10); end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        logic [31:0] oa [6], ob [6];
        int sent = 0, rcv = 0, cyc = 0, first_c = -1, last_c = -1;
        for (int i = 0; i < 6; i++) begin oa[i] = rand_op(); ob[i] = rand_op(); end
        out_ready = 1'b1;
        while (rcv < 6 && cyc < 40) begin
            in_valid = (sent < 6);
            if (sent < 6) begin in_a = oa[sent]; in_b = ob[sent]; in_tag = 4'(sent + 8); end
            #1;
            if (in_valid) begin
                n_checks++; if (ir10 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1 at op %0d", ir10, sent); end
            end
            if (ov10) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                if (q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_extra got output with tag %h want none", tag10);
                end else begin
                    e = q.pop_front();
                    n_checks++; if ({tag10, exc10, p10} !== {e.tag, e.r10}) begin n_fail++; $display("FAIL b2b_r10 got %h %b %h want %h %b %h", tag10, exc10, p10, e.tag, e.r10[35:32], e.r10[31:0]); end
                    n_checks++; if ({tag7, exc7, p7} !== {e.tag, e.r7}) begin n_fail++; $display("FAIL b2b_r7 got %h %b %h want %h %b %h", tag7, exc7, p7, e.tag, e.r7[35:32], e.r7[31:0]); end
                end
                rcv++;
            end
            if (in_valid && ir10) begin
                e.tag = in_tag; e.r10 = ref_mul(in_a, in_b, 10); e.r7 = ref_mul(in_a, in_b, 7);
                q.push_back(e);
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++; if (rcv !== 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", rcv); end
        n_checks++; if (first_c !== 3) begin n_fail++; $display("FAIL b2b_first_cycle got %0d want 3", first_c); end
        n_checks++; if (last_c - first_c !== 5) begin n_fail++; $display("FAIL b2b_throughput got span %0d want 5", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        logic [31:0] oa, ob;
        logic [35:0] held;
        logic [3:0]  held_tag;
        logic        stalled = 1'b0, want_ir;
        int sent = 0, rcv = 0, cyc = 0, occ = 0;
        oa = rand_op(); ob = rand_op();
        while (rcv < 8 && cyc < 400) begin
            in_valid  = (sent < 8) && ($urandom_range(0, 9) < 8);
            in_a = oa; in_b = ob; in_tag = 4'(sent);
            out_ready = 1'($urandom);
            #1;
            want_ir = !(occ == 3 && !out_ready);
            n_checks++; if ({ir10, ir7} !== {want_ir, want_ir}) begin n_fail++; $display("FAIL bp_in_ready got %b%b want %b occ %0d", ir10, ir7, want_ir, occ); end
            if (stalled) begin
                n_checks++; if ({ov10, tag10, exc10, p10} !== {1'b1, held_tag, held}) begin n_fail++; $display("FAIL bp_stable got %b %h %b %h want 1 %h %b %h", ov10, tag10, exc10, p10, held_tag, held[35:32], held[31:0]); end
            end
            stalled = ov10 && !out_ready;
            held = {exc10, p10}; held_tag = tag10;
            if (ov10 && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL bp_extra got output with tag %h want none", tag10);
                end else begin
                    e = q.pop_front();
                    n_checks++; if ({tag10, exc10, p10} !== {e.tag, e.r10}) begin n_fail++; $display("FAIL bp_r10 got %h %b %h want %h %b %h", tag10, exc10, p10, e.tag, e.r10[35:32], e.r10[31:0]); end
                    n_checks++; if ({ov7, tag7, exc7, p7} !== {1'b1, e.tag, e.r7}) begin n_fail++; $display("FAIL bp_r7 got %b %h %b %h want 1 %h %b %h", ov7, tag7, exc7, p7, e.tag, e.r7[35:32], e.r7[31:0]); end
                    occ--;
                end
                rcv++;
            end
            if (in_valid && ir10) begin
                e.tag = in_tag; e.r10 = ref_mul(in_a, in_b, 10); e.r7 = ref_mul(in_a, in_b, 7);
                q.push_back(e);
                sent++; occ++;
                oa = rand_op(); ob = rand_op();
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (rcv !== 8 || q.size() !== 0) begin n_fail++; $display("FAIL bp_count got %0d left %0d want 8 left 0", rcv, q.size()); end
    endtask

    task automatic test_reset_mid();
        int seen = 0, lat;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000; in_tag = 4'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        n_checks++; if ({ov10, ir10} !== 2'b01) begin n_fail++; $display("FAIL midrst_state got ov %b ir %b want ov 0 ir 1", ov10, ir10); end
        for (int i = 0; i < 10; i++) begin
            if (ov10 || ov7) seen++;
            tick();
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_flush got %0d outputs want 0", seen); end
        issue_and_wait(32'h3FC00000, 32'h3FC00000, 4'h9, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL midrst_latency got %0d want 3", lat); end
        n_checks++; if ({tag10, exc10, p10} !== {4'h9, 4'b0000, 32'h40100000}) begin n_fail++; $display("FAIL midrst_result got %h %b %h want 9 0000 40100000", tag10, exc10, p10); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; exc_clr = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        test_reset();
        test_directed();
        test_range_sticky();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
